// File: rtl/lib_switchblock_pkg.sv
// Shared types, default widths and helpers for the DEM switching-block tree.
package lib_switchblock_pkg;

  localparam int INPUT_WIDTH        = 16;
  localparam int NUM_LAYERS_DEFAULT = 3;

  typedef logic signed [1:0] sel_t;
  typedef logic signed [1:0] acc_t;

  localparam sel_t SEL_POS  = 2'sd1;
  localparam sel_t SEL_ZERO = 2'sd0;
  localparam sel_t SEL_NEG  = -2'sd1;

  function automatic int out_width(input int input_width, input int num_layers);
    return input_width - num_layers + 1;
  endfunction

endpackage

// File: rtl/dem_switch_cell.sv
// One mismatch-shaping switching cell: splits an odd/even code into two halves.
// Optional build macro DEM_SWITCH_DITHER_EN adds a random tie-break input.
module dem_switch_cell
  import lib_switchblock_pkg::*;
#(
  parameter int CODE_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic                  en,
  input  logic [CODE_WIDTH-1:0] code,
`ifdef DEM_SWITCH_DITHER_EN
  input  logic                  rnd,
`endif
  output logic [CODE_WIDTH-2:0] top,
  output logic [CODE_WIDTH-2:0] bottom
);

  acc_t                  acc;
  sel_t                  sel;
  logic [CODE_WIDTH-1:0] sel_ext;
  logic [CODE_WIDTH-1:0] sum;
  logic [CODE_WIDTH-1:0] diff;

  // The step always drives the running imbalance back towards zero.
  always_comb begin
    sel = SEL_ZERO;
    if (code[0]) begin
      if (!en)
        sel = SEL_POS;
      else if (acc > 0)
        sel = SEL_NEG;
      else if (acc < 0)
        sel = SEL_POS;
`ifdef DEM_SWITCH_DITHER_EN
      else
        sel = rnd ? SEL_POS : SEL_NEG;
`else
      else
        sel = SEL_POS;
`endif
    end
  end

  // code+sel never exceeds 2**(CODE_WIDTH-1) and code-sel never goes negative.
  assign sel_ext = {{(CODE_WIDTH-2){sel[1]}}, sel};
  assign sum     = code + sel_ext;
  assign diff    = code - sel_ext;
  assign top     = (CODE_WIDTH-1)'(sum >> 1);
  assign bottom  = (CODE_WIDTH-1)'(diff >> 1);

  always_ff @(posedge clk) begin
    if (reset)
      acc <= '0;
    else if (valid && en && code[0])
      acc <= acc + sel;
  end

endmodule

// File: rtl/dem_switch_tree.sv
// Pipelined binary tree of DEM switching cells with valid tracking and a sum check.
// Optional build macro DEM_SWITCH_DITHER_EN enables LFSR dither of tie-breaks.
module dem_switch_tree
  import lib_switchblock_pkg::*;
#(
  parameter int INPUT_WIDTH = lib_switchblock_pkg::INPUT_WIDTH,
  parameter int NUM_LAYERS  = lib_switchblock_pkg::NUM_LAYERS_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  input  logic [INPUT_WIDTH-1:0] x_in_i,
  input  logic                 dem_en_i,
  output logic [(2**NUM_LAYERS)*lib_switchblock_pkg::out_width(INPUT_WIDTH, NUM_LAYERS)-1:0] x_out_o,
  output logic                 valid_o,
  output logic                 sum_err_o
);

  localparam int NUM_OUTPUTS = 2**NUM_LAYERS;
  localparam int OUT_WIDTH   = out_width(INPUT_WIDTH, NUM_LAYERS);
  localparam int LAST        = NUM_LAYERS - 1;
  localparam int SUM_WIDTH   = INPUT_WIDTH + NUM_LAYERS;

`ifdef DEM_SWITCH_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      lfsr <= 16'hACE1;
    else if (valid_i)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
    localparam int CW = INPUT_WIDTH - l + 1;
    localparam int NC = 2**l;

    logic [NC*CW-1:0]         code;
    logic                     vld;
    logic                     en;
    logic [INPUT_WIDTH-1:0]   xd;
    logic [2*NC*(CW-1)-1:0]   split;

    // Stage registers hold on bubbles so each cell only ever sees real codes.
    if (l == 0) begin : g_src
      assign code = {1'b0, x_in_i};
      assign vld  = valid_i;
      assign en   = dem_en_i;
      assign xd   = x_in_i;
    end else begin : g_src
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          code <= '0;
          vld  <= 1'b0;
          en   <= 1'b0;
          xd   <= '0;
        end else begin
          vld <= g_layer[l-1].vld;
          if (g_layer[l-1].vld) begin
            code <= g_layer[l-1].split;
            en   <= g_layer[l-1].en;
            xd   <= g_layer[l-1].xd;
          end
        end
      end
    end

    for (genvar k = 0; k < NC; k++) begin : g_cell
      dem_switch_cell #(
        .CODE_WIDTH(CW)
      ) u_cell (
        .clk    (clk_i),
        .reset  (reset_i),
        .valid  (vld),
        .en     (en),
        .code   (code[k*CW +: CW]),
`ifdef DEM_SWITCH_DITHER_EN
        .rnd    (lfsr[l]),
`endif
        .top    (split[(2*k)*(CW-1) +: CW-1]),
        .bottom (split[(2*k+1)*(CW-1) +: CW-1])
      );
    end
  end

  logic [INPUT_WIDTH-1:0] x_ref;
  logic [SUM_WIDTH-1:0]   leaf_sum;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_out_o <= '0;
      valid_o <= 1'b0;
      x_ref   <= '0;
    end else begin
      valid_o <= g_layer[LAST].vld;
      if (g_layer[LAST].vld) begin
        x_out_o <= g_layer[LAST].split;
        x_ref   <= g_layer[LAST].xd;
      end
    end
  end

  always_comb begin
    leaf_sum = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++)
      leaf_sum = leaf_sum + SUM_WIDTH'(x_out_o[k*OUT_WIDTH +: OUT_WIDTH]);
  end

  // Leaves must always add back up to the code that produced them.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      sum_err_o <= 1'b0;
    else if (valid_o && (leaf_sum != SUM_WIDTH'(x_ref)))
      sum_err_o <= 1'b1;
  end

endmodule

// File: tb/tb_dem_switch_tree.sv
// Bench for dem_switch_tree: 3-layer and 4-layer instances against a tree-walking model.
module tb_dem_switch_tree;

  localparam int W = 16;

  typedef struct {
    bit           v;
    logic [255:0] vec;
  } pipe_t;

  logic          clk_i;
  logic          reset_i;
  logic          valid_i;
  logic [W-1:0]  x_in_i;
  logic          dem_en_i;

  logic [111:0]  x_out3;
  logic          valid3;
  logic          err3;
  logic [207:0]  x_out4;
  logic          valid4;
  logic          err4;

  int            n_checks = 0;
  int            n_fail   = 0;

  int            nl_of [2] = '{3, 4};
  int            macc [2][6][64];
  pipe_t         pq [2][$];
  bit            exp_v [2];
  logic [255:0]  exp_vec [2];

  dem_switch_tree #(.INPUT_WIDTH(W), .NUM_LAYERS(3)) dut3 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .x_in_i(x_in_i),
    .dem_en_i(dem_en_i), .x_out_o(x_out3), .valid_o(valid3), .sum_err_o(err3)
  );

  dem_switch_tree #(.INPUT_WIDTH(W), .NUM_LAYERS(4)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .x_in_i(x_in_i),
    .dem_en_i(dem_en_i), .x_out_o(x_out4), .valid_o(valid4), .sum_err_o(err4)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Walk one code down the whole tree at once; each cell sees its codes in the same order as the pipeline.
  task automatic model_tree(input int inst, input int nl, input int x, input bit en,
                            output logic [255:0] vec);
    int codes [64];
    int nxt [64];
    int c;
    int s;
    int ow;
    codes[0] = x;
    for (int l = 0; l < nl; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        c = codes[k];
        if (c % 2 == 0)                 s = 0;
        else if (!en)                   s = 1;
        else if (macc[inst][l][k] > 0)  s = -1;
        else                            s = 1;
        if ((c % 2 == 1) && en) macc[inst][l][k] += s;
        nxt[2*k]   = (c + s) / 2;
        nxt[2*k+1] = (c - s) / 2;
      end
      codes = nxt;
    end
    ow  = W - nl + 1;
    vec = '0;
    for (int k = 0; k < (1 << nl); k++)
      vec = vec | (256'(codes[k]) << (k * ow));
  endtask

  function automatic logic [255:0] pack_leaves(input int nl, input int vals [16]);
    logic [255:0] r;
    int ow;
    r  = '0;
    ow = W - nl + 1;
    for (int k = 0; k < (1 << nl); k++)
      r = r | (256'(vals[k]) << (k * ow));
    return r;
  endfunction

  function automatic int sum_leaves(input int nl, input logic [255:0] vec);
    int ow;
    int acc;
    ow  = W - nl + 1;
    acc = 0;
    for (int k = 0; k < (1 << nl); k++)
      acc += int'((vec >> (k * ow)) & ((256'(1) << ow) - 1));
    return acc;
  endfunction

  function automatic int leaf_of(input int nl, input logic [255:0] vec, input int k);
    int ow;
    ow = W - nl + 1;
    return int'((vec >> (k * ow)) & ((256'(1) << ow) - 1));
  endfunction

  task automatic check_output();
    check("valid_o_l3",   256'(valid3), 256'(exp_v[0]));
    check("x_out_o_l3",   256'(x_out3), exp_vec[0]);
    check("sum_err_o_l3", 256'(err3),   256'(0));
    check("valid_o_l4",   256'(valid4), 256'(exp_v[1]));
    check("x_out_o_l4",   256'(x_out4), exp_vec[1]);
    check("sum_err_o_l4", 256'(err4),   256'(0));
  endtask

  task automatic apply_stimulus(input bit v, input int x, input bit en);
    valid_i  = v;
    x_in_i   = W'(x);
    dem_en_i = en;
  endtask

  // Advance one clock: update the model with the inputs about to be sampled, then compare.
  task automatic step();
    pipe_t e;
    logic [255:0] mv;
    for (int i = 0; i < 2; i++) begin
      if (reset_i) begin
        pq[i].delete();
        for (int l = 0; l < 6; l++)
          for (int k = 0; k < 64; k++)
            macc[i][l][k] = 0;
        exp_v[i]   = 1'b0;
        exp_vec[i] = '0;
      end else begin
        e.v   = valid_i;
        e.vec = '0;
        if (valid_i) begin
          model_tree(i, nl_of[i], int'(x_in_i), dem_en_i, mv);
          e.vec = mv;
        end
        pq[i].push_back(e);
        if (pq[i].size() == nl_of[i]) begin
          e = pq[i].pop_front();
          exp_v[i] = e.v;
          if (e.v) exp_vec[i] = e.vec;
        end
      end
    end
    @(posedge clk_i);
    #1;
    check_output();
  endtask

  initial begin
    int   vals [16];
    logic [7:0] mask;
    int   cnt;
    int   idx;
    logic [2:0] vpat;

    reset_i = 1'b1;
    apply_stimulus(0, 0, 1);
    step();
    step();
    check("reset_x_out_o", 256'(x_out3), 256'(0));
    check("reset_valid_o", 256'(valid3), 256'(0));

    // Two back-to-back x=5 codes
    reset_i = 1'b0;
    apply_stimulus(1, 5, 1); step();
    apply_stimulus(1, 5, 1); step();
    apply_stimulus(0, 0, 1); step();
    vals = '{1,1,1,0,1,0,1,0,0,0,0,0,0,0,0,0};
    check("first_x5_leaves", 256'(x_out3), pack_leaves(3, vals));
    check("first_x5_valid",  256'(valid3), 256'(1));
    step();
    vals = '{1,0,0,1,1,1,0,1,0,0,0,0,0,0,0,0};
    check("second_x5_leaves", 256'(x_out3), pack_leaves(3, vals));
    step();
    check("valid_pulse_end",  256'(valid3), 256'(0));
    check("bubble_hold",      256'(x_out3), pack_leaves(3, vals));
    check("x5_sum_err",       256'(err3),   256'(0));

    // Full-scale input
    reset_i = 1'b1; step();
    reset_i = 1'b0;
    apply_stimulus(1, 65535, 1); step();
    apply_stimulus(0, 0, 1); step();
    step();
    vals = '{8192,8192,8192,8192,8192,8192,8192,8191,0,0,0,0,0,0,0,0};
    check("max_leaves", 256'(x_out3), pack_leaves(3, vals));
    step();
    check("max_sum_l4", 256'(sum_leaves(4, 256'(x_out4))), 256'(65535));

    // Four-layer latency with x=9
    reset_i = 1'b1; step();
    reset_i = 1'b0;
    apply_stimulus(1, 9, 1); step();
    apply_stimulus(0, 0, 1); step();
    step();
    check("l4_not_yet_valid", 256'(valid4), 256'(0));
    step();
    check("l4_valid_at_4",    256'(valid4), 256'(1));
    check("l4_sum_9",         256'(sum_leaves(4, 256'(x_out4))), 256'(9));

    // A single 1 rotates through every leaf with shaping on
    reset_i = 1'b1; step();
    reset_i = 1'b0;
    mask = '0;
    cnt  = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) apply_stimulus(1, 1, 1);
      else       apply_stimulus(0, 0, 1);
      step();
      if (valid3) begin
        cnt++;
        for (int k = 0; k < 8; k++)
          if (leaf_of(3, 256'(x_out3), k) == 1) mask[k] = 1'b1;
      end
    end
    check("ones_visit_all", 256'(mask), 256'(8'hFF));
    check("ones_count",     256'(cnt),  256'(8));

    // Shaping off: every 1 lands on leaf 0
    cnt = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) apply_stimulus(1, 1, 0);
      else       apply_stimulus(0, 0, 0);
      step();
      idx = leaf_of(3, 256'(x_out3), 0);
      if (valid3 && idx == 1 && sum_leaves(3, 256'(x_out3)) == 1) cnt++;
    end
    check("fixed_split_leaf0", 256'(cnt), 256'(8));

    // Bubble in the middle of a stream
    apply_stimulus(1, 3, 1); step();
    apply_stimulus(0, 7, 1); step();
    apply_stimulus(1, 3, 1); step();
    vpat[2] = valid3;
    apply_stimulus(0, 0, 1); step();
    vpat[1] = valid3;
    step();
    vpat[0] = valid3;
    check("bubble_pattern", 256'(vpat), 256'(3'b101));
    step();

    // Reset with codes in flight
    apply_stimulus(1, 100, 1); step();
    apply_stimulus(1, 200, 1); step();
    reset_i = 1'b1; step();
    check("midreset_x_out", 256'(x_out3), 256'(0));
    check("midreset_valid", 256'(valid3), 256'(0));
    reset_i = 1'b0;
    apply_stimulus(0, 0, 1);
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset_i = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 9))
        0:       idx = 0;
        1:       idx = 65535;
        2:       idx = $urandom_range(0, 15);
        default: idx = $urandom_range(0, 65535);
      endcase
      apply_stimulus($urandom_range(0, 3) != 0, idx, $urandom_range(0, 4) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
